// File: rtl/ecc_hamming_74_codec.sv
// ecc_hamming_74_codec
// Registered (7,4) Hamming SECDED codec with independent encode and decode
// pipes, each one register stage deep. Sits between a datapath and a narrow
// storage/link that needs single-error correction.
//
// Parameter:
//   SECDED            1 = generate/check the extra overall parity bit
//                     0 = plain Hamming(7,4), extra parity forced/ignored
// Optional macro:
//   ECC_ERR_CNT_EN    when defined, saturating 16-bit single/double error
//                     counters are built; otherwise both outputs are tied to 0
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enc_valid, enc_din       encoder input qualifier and 4-bit data
//   enc_out_valid            encoder output qualifier (enc_valid delayed 1)
//   enc_codeword             7-bit codeword {d3,d2,d1,p4,d0,p2,p1}
//   enc_extra_parity         even overall parity of the codeword
//   dec_valid, dec_codeword  decoder input qualifier and received word
//   dec_extra_parity         received overall parity bit
//   dec_out_valid            decoder output qualifier (dec_valid delayed 1)
//   dec_dout                 corrected data {c6,c5,c4,c2}
//   dec_error_single_bit     single error detected and corrected
//   dec_error_double_bit     uncorrectable double error
//   dec_syndrome             raw syndrome {s4,s2,s1}
//   err_single_cnt           accepted decodes flagged single (saturating)
//   err_double_cnt           accepted decodes flagged double (saturating)

module ecc_hamming_74_codec #(
  parameter bit SECDED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_valid,
  input  logic [3:0]  enc_din,
  output logic        enc_out_valid,
  output logic [6:0]  enc_codeword,
  output logic        enc_extra_parity,
  input  logic        dec_valid,
  input  logic [6:0]  dec_codeword,
  input  logic        dec_extra_parity,
  output logic        dec_out_valid,
  output logic [3:0]  dec_dout,
  output logic        dec_error_single_bit,
  output logic        dec_error_double_bit,
  output logic [2:0]  dec_syndrome,
  output logic [15:0] err_single_cnt,
  output logic [15:0] err_double_cnt
);

  logic       enc_out_valid_q, enc_out_valid_d;
  logic [6:0] enc_codeword_q, enc_codeword_d;
  logic       enc_extra_parity_q, enc_extra_parity_d;
  logic       dec_out_valid_q, dec_out_valid_d;
  logic [3:0] dec_dout_q, dec_dout_d;
  logic       dec_single_q, dec_single_d;
  logic       dec_double_q, dec_double_d;
  logic [2:0] dec_syndrome_q, dec_syndrome_d;

  logic [6:0] enc_cw;
  logic [2:0] syn;
  logic       op;
  logic       single_now;
  logic       double_now;
  logic       do_correct;
  logic [6:0] flip_mask;
  logic [6:0] corrected;

  // Encoder: parity bits sit at the power-of-two Hamming positions.
  always_comb begin
    enc_cw[0] = enc_din[0] ^ enc_din[1] ^ enc_din[3];
    enc_cw[1] = enc_din[0] ^ enc_din[2] ^ enc_din[3];
    enc_cw[2] = enc_din[0];
    enc_cw[3] = enc_din[1] ^ enc_din[2] ^ enc_din[3];
    enc_cw[4] = enc_din[1];
    enc_cw[5] = enc_din[2];
    enc_cw[6] = enc_din[3];

    enc_out_valid_d    = enc_valid;
    enc_codeword_d     = enc_codeword_q;
    enc_extra_parity_d = enc_extra_parity_q;
    if (enc_valid) begin
      enc_codeword_d     = enc_cw;
      enc_extra_parity_d = SECDED ? (^enc_cw) : 1'b0;
    end
  end

  // Decoder: op separates odd-weight errors (correctable) from even-weight
  // ones; without SECDED every nonzero syndrome is treated as correctable.
  always_comb begin
    syn[0] = dec_codeword[0] ^ dec_codeword[2] ^ dec_codeword[4] ^ dec_codeword[6];
    syn[1] = dec_codeword[1] ^ dec_codeword[2] ^ dec_codeword[5] ^ dec_codeword[6];
    syn[2] = dec_codeword[3] ^ dec_codeword[4] ^ dec_codeword[5] ^ dec_codeword[6];
    op     = SECDED ? ((^dec_codeword) ^ dec_extra_parity) : 1'b0;

    if (SECDED) begin
      do_correct = (syn != 3'd0) && op;
      single_now = op;
      double_now = (syn != 3'd0) && !op;
    end else begin
      do_correct = (syn != 3'd0);
      single_now = (syn != 3'd0);
      double_now = 1'b0;
    end

    for (int i = 0; i < 7; i++) begin
      flip_mask[i] = do_correct && (syn == 3'(i + 1));
    end
    corrected = dec_codeword ^ flip_mask;

    dec_out_valid_d = dec_valid;
    dec_dout_d      = dec_dout_q;
    dec_single_d    = dec_single_q;
    dec_double_d    = dec_double_q;
    dec_syndrome_d  = dec_syndrome_q;
    if (dec_valid) begin
      dec_dout_d     = {corrected[6], corrected[5], corrected[4], corrected[2]};
      dec_single_d   = single_now;
      dec_double_d   = double_now;
      dec_syndrome_d = syn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_out_valid_q    <= 1'b0;
      enc_codeword_q     <= '0;
      enc_extra_parity_q <= 1'b0;
      dec_out_valid_q    <= 1'b0;
      dec_dout_q         <= '0;
      dec_single_q       <= 1'b0;
      dec_double_q       <= 1'b0;
      dec_syndrome_q     <= '0;
    end else begin
      enc_out_valid_q    <= enc_out_valid_d;
      enc_codeword_q     <= enc_codeword_d;
      enc_extra_parity_q <= enc_extra_parity_d;
      dec_out_valid_q    <= dec_out_valid_d;
      dec_dout_q         <= dec_dout_d;
      dec_single_q       <= dec_single_d;
      dec_double_q       <= dec_double_d;
      dec_syndrome_q     <= dec_syndrome_d;
    end
  end

  assign enc_out_valid        = enc_out_valid_q;
  assign enc_codeword         = enc_codeword_q;
  assign enc_extra_parity     = enc_extra_parity_q;
  assign dec_out_valid        = dec_out_valid_q;
  assign dec_dout             = dec_dout_q;
  assign dec_error_single_bit = dec_single_q;
  assign dec_error_double_bit = dec_double_q;
  assign dec_syndrome         = dec_syndrome_q;

`ifdef ECC_ERR_CNT_EN
  logic [15:0] err_single_cnt_q, err_single_cnt_d;
  logic [15:0] err_double_cnt_q, err_double_cnt_d;

  // Counters saturate at all-ones so a long error burst never wraps to a
  // misleadingly small value.
  always_comb begin
    err_single_cnt_d = err_single_cnt_q;
    err_double_cnt_d = err_double_cnt_q;
    if (dec_valid && single_now && (err_single_cnt_q != 16'hFFFF)) begin
      err_single_cnt_d = err_single_cnt_q + 16'd1;
    end
    if (dec_valid && double_now && (err_double_cnt_q != 16'hFFFF)) begin
      err_double_cnt_d = err_double_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_single_cnt_q <= '0;
      err_double_cnt_q <= '0;
    end else begin
      err_single_cnt_q <= err_single_cnt_d;
      err_double_cnt_q <= err_double_cnt_d;
    end
  end

  assign err_single_cnt = err_single_cnt_q;
  assign err_double_cnt = err_double_cnt_q;
`else
  assign err_single_cnt = '0;
  assign err_double_cnt = '0;
`endif

endmodule

// File: tb/tb_ecc_hamming_74_codec.sv
// tb_ecc_hamming_74_codec
// Directed testbench for ecc_hamming_74_codec. Two instances share the same
// stimulus: dut (SECDED=1) and dut_plain (SECDED=0). Expected codewords and
// parities are hand-computed constants. When ECC_ERR_CNT_EN is defined the
// counter expectations follow the injected error count, otherwise they are 0.

module tb_ecc_hamming_74_codec;

  logic        clk;
  logic        rst;
  logic        enc_valid;
  logic [3:0]  enc_din;
  logic        dec_valid;
  logic [6:0]  dec_codeword;
  logic        dec_extra_parity;

  logic        enc_out_valid;
  logic [6:0]  enc_codeword;
  logic        enc_extra_parity;
  logic        dec_out_valid;
  logic [3:0]  dec_dout;
  logic        dec_error_single_bit;
  logic        dec_error_double_bit;
  logic [2:0]  dec_syndrome;
  logic [15:0] err_single_cnt;
  logic [15:0] err_double_cnt;

  logic        p_enc_out_valid;
  logic [6:0]  p_enc_codeword;
  logic        p_enc_extra_parity;
  logic        p_dec_out_valid;
  logic [3:0]  p_dec_dout;
  logic        p_dec_error_single_bit;
  logic        p_dec_error_double_bit;
  logic [2:0]  p_dec_syndrome;
  logic [15:0] p_err_single_cnt;
  logic [15:0] p_err_double_cnt;

  int errors = 0;
  int checks = 0;

  // Hand-computed codewords {d3,d2,d1,p4,d0,p2,p1} for data 0..15.
  logic [6:0]  cw_table [0:15];
  // Bit d holds the even overall parity of cw_table[d].
  logic [15:0] par_table;
  logic [6:0]  one_hot;

`ifdef ECC_ERR_CNT_EN
  localparam logic [15:0] EXP_CNT3 = 16'd3;
`else
  localparam logic [15:0] EXP_CNT3 = 16'd0;
`endif

  ecc_hamming_74_codec #(.SECDED(1'b1)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enc_valid            (enc_valid),
    .enc_din              (enc_din),
    .enc_out_valid        (enc_out_valid),
    .enc_codeword         (enc_codeword),
    .enc_extra_parity     (enc_extra_parity),
    .dec_valid            (dec_valid),
    .dec_codeword         (dec_codeword),
    .dec_extra_parity     (dec_extra_parity),
    .dec_out_valid        (dec_out_valid),
    .dec_dout             (dec_dout),
    .dec_error_single_bit (dec_error_single_bit),
    .dec_error_double_bit (dec_error_double_bit),
    .dec_syndrome         (dec_syndrome),
    .err_single_cnt       (err_single_cnt),
    .err_double_cnt       (err_double_cnt)
  );

  ecc_hamming_74_codec #(.SECDED(1'b0)) dut_plain (
    .clk                  (clk),
    .rst                  (rst),
    .enc_valid            (enc_valid),
    .enc_din              (enc_din),
    .enc_out_valid        (p_enc_out_valid),
    .enc_codeword         (p_enc_codeword),
    .enc_extra_parity     (p_enc_extra_parity),
    .dec_valid            (dec_valid),
    .dec_codeword         (dec_codeword),
    .dec_extra_parity     (dec_extra_parity),
    .dec_out_valid        (p_dec_out_valid),
    .dec_dout             (p_dec_dout),
    .dec_error_single_bit (p_dec_error_single_bit),
    .dec_error_double_bit (p_dec_error_double_bit),
    .dec_syndrome         (p_dec_syndrome),
    .err_single_cnt       (p_err_single_cnt),
    .err_double_cnt       (p_err_double_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the rising edge take them, sample 1ns later.
  task automatic applyStimulus(input logic ev, input logic [3:0] ed,
                               input logic dv, input logic [6:0] dcw,
                               input logic dx);
    enc_valid        = ev;
    enc_din          = ed;
    dec_valid        = dv;
    dec_codeword     = dcw;
    dec_extra_parity = dx;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    cw_table = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                 7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};
    par_table = 16'h9696;

    // Reset asserted together with both valids: reset must win.
    rst = 1'b1;
    applyStimulus(1'b1, 4'hB, 1'b1, 7'h45, 1'b0);
    checkOutput("rst_enc_valid", 32'(enc_out_valid), 32'd0);
    checkOutput("rst_enc_cw", 32'(enc_codeword), 32'd0);
    checkOutput("rst_enc_par", 32'(enc_extra_parity), 32'd0);
    checkOutput("rst_dec_valid", 32'(dec_out_valid), 32'd0);
    checkOutput("rst_dec_dout", 32'(dec_dout), 32'd0);
    checkOutput("rst_dec_single", 32'(dec_error_single_bit), 32'd0);
    checkOutput("rst_dec_double", 32'(dec_error_double_bit), 32'd0);
    checkOutput("rst_dec_syn", 32'(dec_syndrome), 32'd0);
    checkOutput("rst_cnt_single", 32'(err_single_cnt), 32'd0);
    checkOutput("rst_cnt_double", 32'(err_double_cnt), 32'd0);
    rst = 1'b0;

    // Encode sweep of all 16 data values.
    for (int d = 0; d < 16; d++) begin
      applyStimulus(1'b1, 4'(d), 1'b0, 7'h00, 1'b0);
      checkOutput($sformatf("enc_valid_%0d", d), 32'(enc_out_valid), 32'd1);
      checkOutput($sformatf("enc_cw_%0d", d), 32'(enc_codeword), 32'(cw_table[d]));
      checkOutput($sformatf("enc_par_%0d", d), 32'(enc_extra_parity), 32'(par_table[d]));
      checkOutput($sformatf("plain_enc_cw_%0d", d), 32'(p_enc_codeword), 32'(cw_table[d]));
      checkOutput($sformatf("plain_enc_par_%0d", d), 32'(p_enc_extra_parity), 32'd0);
    end

    // Encoder holds when enc_valid is low.
    applyStimulus(1'b0, 4'h3, 1'b0, 7'h00, 1'b0);
    checkOutput("enc_hold_valid", 32'(enc_out_valid), 32'd0);
    checkOutput("enc_hold_cw", 32'(enc_codeword), 32'h7F);
    checkOutput("enc_hold_par", 32'(enc_extra_parity), 32'd1);

    // Clean decode.
    applyStimulus(1'b0, 4'h0, 1'b1, 7'h55, 1'b0);
    checkOutput("clean_valid", 32'(dec_out_valid), 32'd1);
    checkOutput("clean_dout", 32'(dec_dout), 32'hB);
    checkOutput("clean_syn", 32'(dec_syndrome), 32'd0);
    checkOutput("clean_single", 32'(dec_error_single_bit), 32'd0);
    checkOutput("clean_double", 32'(dec_error_double_bit), 32'd0);

    // Decoder holds when dec_valid is low.
    applyStimulus(1'b0, 4'h0, 1'b0, 7'h56, 1'b0);
    checkOutput("dec_hold_valid", 32'(dec_out_valid), 32'd0);
    checkOutput("dec_hold_dout", 32'(dec_dout), 32'hB);
    checkOutput("dec_hold_syn", 32'(dec_syndrome), 32'd0);
    checkOutput("dec_hold_double", 32'(dec_error_double_bit), 32'd0);

    // Error only in the extra parity bit.
    applyStimulus(1'b0, 4'h0, 1'b1, 7'h55, 1'b1);
    checkOutput("xpar_syn", 32'(dec_syndrome), 32'd0);
    checkOutput("xpar_single", 32'(dec_error_single_bit), 32'd1);
    checkOutput("xpar_double", 32'(dec_error_double_bit), 32'd0);
    checkOutput("xpar_dout", 32'(dec_dout), 32'hB);
    checkOutput("plain_xpar_single", 32'(p_dec_error_single_bit), 32'd0);

    // Single error at bit 4.
    applyStimulus(1'b0, 4'h0, 1'b1, 7'h45, 1'b0);
    checkOutput("single_syn", 32'(dec_syndrome), 32'd5);
    checkOutput("single_dout", 32'(dec_dout), 32'hB);
    checkOutput("single_flag", 32'(dec_error_single_bit), 32'd1);
    checkOutput("single_double", 32'(dec_error_double_bit), 32'd0);

    // Double error at bits 0 and 1: SECDED flags it, plain miscorrects bit 2.
    applyStimulus(1'b0, 4'h0, 1'b1, 7'h56, 1'b0);
    checkOutput("double_syn", 32'(dec_syndrome), 32'd3);
    checkOutput("double_flag", 32'(dec_error_double_bit), 32'd1);
    checkOutput("double_single", 32'(dec_error_single_bit), 32'd0);
    checkOutput("double_dout", 32'(dec_dout), 32'hB);
    checkOutput("plain_double_single", 32'(p_dec_error_single_bit), 32'd1);
    checkOutput("plain_double_double", 32'(p_dec_error_double_bit), 32'd0);
    checkOutput("plain_double_syn", 32'(p_dec_syndrome), 32'd3);
    checkOutput("plain_double_dout", 32'(p_dec_dout), 32'hA);

    // Every single-bit error position for every data value.
    for (int d = 0; d < 16; d++) begin
      for (int b = 0; b < 7; b++) begin
        one_hot = 7'b1 << b;
        applyStimulus(1'b0, 4'h0, 1'b1, cw_table[d] ^ one_hot, par_table[d]);
        checkOutput($sformatf("sweep_syn_d%0d_b%0d", d, b), 32'(dec_syndrome), 32'(b + 1));
        checkOutput($sformatf("sweep_dout_d%0d_b%0d", d, b), 32'(dec_dout), 32'(d));
        checkOutput($sformatf("sweep_single_d%0d_b%0d", d, b), 32'(dec_error_single_bit), 32'd1);
        checkOutput($sformatf("sweep_double_d%0d_b%0d", d, b), 32'(dec_error_double_bit), 32'd0);
        checkOutput($sformatf("plain_sweep_dout_d%0d_b%0d", d, b), 32'(p_dec_dout), 32'(d));
      end
    end

    // Reset mid-stream with a valid word in flight.
    rst = 1'b1;
    applyStimulus(1'b1, 4'h7, 1'b1, 7'h56, 1'b0);
    checkOutput("rst2_dec_valid", 32'(dec_out_valid), 32'd0);
    checkOutput("rst2_dec_dout", 32'(dec_dout), 32'd0);
    checkOutput("rst2_dec_syn", 32'(dec_syndrome), 32'd0);
    checkOutput("rst2_enc_cw", 32'(enc_codeword), 32'd0);
    checkOutput("rst2_cnt_single", 32'(err_single_cnt), 32'd0);
    rst = 1'b0;

    // Three single errors, one clean word, then check the counters.
    applyStimulus(1'b0, 4'h0, 1'b1, 7'h45, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 7'h54, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 7'h55, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b1, 7'h55, 1'b0);
    checkOutput("cnt_single", 32'(err_single_cnt), 32'(EXP_CNT3));
    checkOutput("cnt_double", 32'(err_double_cnt), 32'd0);
    checkOutput("plain_cnt_double", 32'(p_err_double_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecc_hamming_74_codec.md
Name: ecc_hamming_74_codec

Overview:
- Registered (7,4) Hamming SECDED codec: one encode pipe and one independent decode pipe, one register stage each.
- Encoder maps 4 data bits to a 7-bit codeword plus an overall parity bit.
- Decoder computes the syndrome, corrects single-bit errors and flags double-bit errors.
- Sits between a datapath and a narrow storage/link that needs single-error correction.

Parameters:
- SECDED, 1, 1 = generate and check extra overall parity; 0 = plain Hamming(7,4).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- enc_valid  in  1  encoder input qualifier
- enc_din  in  4  data to encode
- enc_out_valid  out  1  encoder output qualifier
- enc_codeword  out  7  encoded word
- enc_extra_parity  out  1  overall parity bit
- dec_valid  in  1  decoder input qualifier
- dec_codeword  in  7  received word
- dec_extra_parity  in  1  received overall parity
- dec_out_valid  out  1  decoder output qualifier
- dec_dout  out  4  corrected data
- dec_error_single_bit  out  1  single-bit error detected (corrected)
- dec_error_double_bit  out  1  uncorrectable double-bit error
- dec_syndrome  out  3  syndrome value
- err_single_cnt  out  16  see Optional Feature
- err_double_cnt  out  16  see Optional Feature

Behaviour:
- Reset: every output register clears to 0, including valids, data, flags, syndrome and counters.
  - Reset wins over a simultaneous valid.
  - Reset mid-stream discards any in-flight word.
- Latency: exactly 1 cycle on both paths.
  - out_valid equals the input valid registered.
  - Data/flag registers load only when the matching valid is 1 and hold otherwise.
  - No backpressure; a new word may be accepted every cycle.
- Codeword layout (Hamming position p = bit index + 1):
  - [0]=p1, [1]=p2, [2]=d0, [3]=p4, [4]=d1, [5]=d2, [6]=d3.
  - p1 = d0^d1^d3; p2 = d0^d2^d3; p4 = d1^d2^d3.
- Extra parity = XOR of the 7 codeword bits (even overall parity). It is forced to 0 when SECDED=0.
- Syndrome = {s4,s2,s1}:
  - s1 = c0^c2^c4^c6; s2 = c1^c2^c5^c6; s4 = c3^c4^c5^c6.
  - A nonzero syndrome S names the faulty bit at index S-1.
- Overall check op = XOR(dec_codeword) ^ dec_extra_parity.
- SECDED=1 decode cases:
  - syn=0, op=0: no error.
  - syn≠0, op=1: single error; flip bit S-1 before extracting data; single=1.
  - syn=0, op=1: error in the extra parity bit only; single=1; data unchanged.
  - syn≠0, op=0: double error; double=1, single=0; dout = uncorrected data bits.
- SECDED=0 decode:
  - dec_extra_parity is ignored and double is always 0.
  - syn≠0 gives single=1 with correction.
- dec_dout = {c6,c5,c4,c2} of the (possibly corrected) word.
- dec_syndrome is always reported raw, including on double errors.

Optional Feature:
- Macro ECC_ERR_CNT_EN.
- Defined:
  - err_single_cnt increments on each accepted decode with single=1.
  - err_double_cnt increments on each accepted decode with double=1.
  - Both counters are 16-bit and saturate at 16'hFFFF (no wrap).
  - Both clear on rst.
- Undefined: both counter outputs are tied to 0 and no counter logic is synthesized.

Test Plan:
- Encode sweep: enc_din=4'hB → codeword 7'h55, parity 0; 4'h0 → 7'h00, 0; 4'hF → 7'h7F, 1. Each output appears one cycle after enc_valid; cover all 16 values against a golden model.
- Clean decode: codeword 7'h55, extra 0 → dout 4'hB, syndrome 0, single 0, double 0.
- Single error: codeword 7'h45 (bit 4 flipped), extra 0 → syndrome 5, dout 4'hB, single 1, double 0. Repeat for all 7 bit positions and all 16 data values.
- Parity-bit error: codeword 7'h55, extra 1 → syndrome 0, single 1, dout 4'hB.
- Double error: codeword 7'h56, extra 0 → syndrome 3, double 1, single 0, dout 4'hB. Same stimulus with SECDED=0 → single 1, double 0.
- Reset/hold: assert rst together with dec_valid → all outputs 0 next cycle. With valid low, outputs hold. With ECC_ERR_CNT_EN, inject 3 single errors → err_single_cnt=3.
